// File: rtl/main_controller_multicycle_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : main_controller_multicycle_if                                |
// | Purpose   : Bundles the instruction fields, memory/mul-div handshakes    |
// |             and datapath control lines of the multicycle controller.     |
// | Ports     : master - controller side (decodes IR fields, drives control) |
// |             slave  - datapath side (supplies IR fields, consumes control)|
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface main_controller_multicycle_if #(
    parameter int CNT_W = 32
);
    // Datapath -> controller
    logic [6:0]       Opcode;
    logic [2:0]       Funct3;
    logic [6:0]       Funct7;
    logic [1:0]       Comp;
    logic             MemReady;
    logic             MulDivDone;
    // Controller -> datapath
    logic             MemRead;
    logic             MemWrite;
    logic             AddrSrc;
    logic             IRWrite;
    logic             PCWrite;
    logic [1:0]       PCSrc;
    logic [3:0]       ALUOp;
    logic [1:0]       ALUSrcB;
    logic             RegWrite;
    logic [2:0]       WritebackSrc;
    logic             MulDivStart;
    logic             Illegal;
    logic             BusError;
    logic [CNT_W-1:0] Retired;

    modport master (
        input  Opcode, Funct3, Funct7, Comp, MemReady, MulDivDone,
        output MemRead, MemWrite, AddrSrc, IRWrite, PCWrite, PCSrc, ALUOp,
               ALUSrcB, RegWrite, WritebackSrc, MulDivStart, Illegal,
               BusError, Retired
    );

    modport slave (
        output Opcode, Funct3, Funct7, Comp, MemReady, MulDivDone,
        input  MemRead, MemWrite, AddrSrc, IRWrite, PCWrite, PCSrc, ALUOp,
               ALUSrcB, RegWrite, WritebackSrc, MulDivStart, Illegal,
               BusError, Retired
    );
endinterface
`default_nettype wire

// File: rtl/main_controller_multicycle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : main_controller_multicycle                                   |
// | Purpose   : Multicycle RV32 subset control FSM (FETCH, DECODE, EXEC,     |
// |             MULDIV, MEM, WB, HALT) with memory wait timeout, sticky      |
// |             illegal/bus-error flags and a retired-instruction counter.   |
// | Ports     : clk - rising-edge clock                                      |
// |             rst - synchronous active-high reset                          |
// |             bus - controller (master) side of the control interface      |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module main_controller_multicycle #(
    parameter int ENABLE_MULDIV = 1,
    parameter int MEM_TIMEOUT   = 255,
    parameter int CNT_W         = 32
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    main_controller_multicycle_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MULDIV = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        K_ILL    = 4'd0,
        K_ALU_R  = 4'd1,
        K_ALU_I  = 4'd2,
        K_MULDIV = 4'd3,
        K_LW     = 4'd4,
        K_SW     = 4'd5,
        K_BR     = 4'd6,
        K_JAL    = 4'd7,
        K_JALR   = 4'd8,
        K_LUI    = 4'd9,
        K_AUIPC  = 4'd10
    } kind_t;

    localparam logic [3:0]  c_ALU_ADD = 4'd0;
    localparam logic [3:0]  c_ALU_SUB = 4'd1;
    localparam logic [3:0]  c_ALU_XOR = 4'd2;
    localparam logic [3:0]  c_ALU_OR  = 4'd3;
    localparam logic [3:0]  c_ALU_AND = 4'd4;
    localparam logic [3:0]  c_ALU_SLL = 4'd5;
    localparam logic [3:0]  c_ALU_SRL = 4'd6;
    localparam logic [3:0]  c_ALU_LST = 4'd7;
    localparam logic [3:0]  c_ALU_MUL = 4'd8;
    localparam logic [3:0]  c_ALU_DIV = 4'd9;
    localparam logic [3:0]  c_ALU_NA  = 4'd15;
    localparam logic [15:0] c_TIMEOUT = 16'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic             illegal_q, illegal_d;
    logic             buserr_q, buserr_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    // Set by reset; keeps the first FETCH cycle after reset from accepting
    // an instruction so IRWrite stays low during that cycle.
    logic             post_rst_q;

    kind_t       w_kind;
    logic [3:0]  w_aluop;
    logic        w_taken;
    logic [15:0] w_wait_inc;

    logic       w_mem_read, w_mem_write, w_addr_src, w_ir_write, w_pc_write;
    logic [1:0] w_pc_src, w_alu_src_b;
    logic [3:0] w_alu_op;
    logic       w_reg_write, w_md_start;
    logic [2:0] w_wb_src;

    // Instruction classification from the held instruction register fields.
    always_comb begin
        w_kind  = K_ILL;
        w_aluop = c_ALU_NA;
        case (bus.Opcode)
            7'h33: begin
                if (bus.Funct7 == 7'h00) begin
                    w_kind = K_ALU_R;
                    case (bus.Funct3)
                        3'd0:    w_aluop = c_ALU_ADD;
                        3'd1:    w_aluop = c_ALU_SLL;
                        3'd2:    w_aluop = c_ALU_LST;
                        3'd4:    w_aluop = c_ALU_XOR;
                        3'd5:    w_aluop = c_ALU_SRL;
                        3'd6:    w_aluop = c_ALU_OR;
                        3'd7:    w_aluop = c_ALU_AND;
                        default: w_kind  = K_ILL;
                    endcase
                end else if (bus.Funct7 == 7'h20 && bus.Funct3 == 3'd0) begin
                    w_kind  = K_ALU_R;
                    w_aluop = c_ALU_SUB;
                end else if (bus.Funct7 == 7'h01 && ENABLE_MULDIV != 0) begin
                    if (bus.Funct3 == 3'd0) begin
                        w_kind  = K_MULDIV;
                        w_aluop = c_ALU_MUL;
                    end else if (bus.Funct3 == 3'd4) begin
                        w_kind  = K_MULDIV;
                        w_aluop = c_ALU_DIV;
                    end
                end
            end
            7'h13: begin
                w_kind = K_ALU_I;
                case (bus.Funct3)
                    3'd0:    w_aluop = c_ALU_ADD;
                    3'd2:    w_aluop = c_ALU_LST;
                    3'd4:    w_aluop = c_ALU_XOR;
                    3'd6:    w_aluop = c_ALU_OR;
                    3'd7:    w_aluop = c_ALU_AND;
                    3'd5: begin
                        // Only the logical shift (srli) is supported.
                        w_aluop = c_ALU_SRL;
                        if (bus.Funct7 != 7'h00) w_kind = K_ILL;
                    end
                    default: w_kind = K_ILL;
                endcase
            end
            7'h03:   if (bus.Funct3 == 3'd2) w_kind = K_LW;
            7'h23:   if (bus.Funct3 == 3'd2) w_kind = K_SW;
            7'h63: begin
                if (bus.Funct3 == 3'd0 || bus.Funct3 == 3'd1 ||
                    bus.Funct3 == 3'd4 || bus.Funct3 == 3'd5) w_kind = K_BR;
            end
            7'h6F:   w_kind = K_JAL;
            7'h67:   if (bus.Funct3 == 3'd0) w_kind = K_JALR;
            7'h37:   w_kind = K_LUI;
            7'h17:   w_kind = K_AUIPC;
            default: w_kind = K_ILL;
        endcase
    end

    // Branch resolution from the comparator flag (0 EQU, 1 LST, 2 GRT, 3 NA).
    always_comb begin
        w_taken = 1'b0;
        case (bus.Funct3)
            3'd0:    w_taken = (bus.Comp == 2'd0);
            3'd1:    w_taken = (bus.Comp != 2'd0);
            3'd4:    w_taken = (bus.Comp == 2'd1);
            3'd5:    w_taken = (bus.Comp == 2'd0) || (bus.Comp == 2'd2);
            default: w_taken = 1'b0;
        endcase
    end

    assign w_wait_inc = wait_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        illegal_d   = illegal_q;
        buserr_d    = buserr_q;
        retired_d   = retired_q;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_addr_src  = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = 2'd3;
        w_alu_op    = c_ALU_NA;
        w_alu_src_b = 2'd3;
        w_reg_write = 1'b0;
        w_wb_src    = 3'd1;
        w_md_start  = 1'b0;

        case (state_q)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (post_rst_q) begin
                    state_d = S_FETCH;
                end else if (bus.MemReady) begin
                    w_ir_write = 1'b1;
                    state_d    = S_DECODE;
                end else if (w_wait_inc == c_TIMEOUT) begin
                    state_d  = S_HALT;
                    buserr_d = 1'b1;
                end else begin
                    wait_d = w_wait_inc;
                end
            end

            S_DECODE: begin
                if (w_kind == K_ILL) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (w_kind)
                    K_ALU_R: begin
                        w_alu_op    = w_aluop;
                        w_alu_src_b = 2'd0;
                        state_d     = S_WB;
                    end
                    K_ALU_I: begin
                        w_alu_op    = w_aluop;
                        w_alu_src_b = 2'd1;
                        state_d     = S_WB;
                    end
                    K_MULDIV: begin
                        w_alu_op    = w_aluop;
                        w_alu_src_b = 2'd0;
                        w_md_start  = 1'b1;
                        state_d     = S_MULDIV;
                    end
                    K_LW, K_SW: begin
                        w_alu_op    = c_ALU_ADD;
                        w_alu_src_b = 2'd1;
                        state_d     = S_MEM;
                    end
                    K_BR: begin
                        w_pc_write = 1'b1;
                        w_pc_src   = w_taken ? 2'd1 : 2'd0;
                        retired_d  = retired_q + c_ONE;
                        state_d    = S_FETCH;
                    end
                    K_JAL, K_JALR, K_LUI, K_AUIPC: begin
                        state_d = S_WB;
                    end
                    default: begin
                        // IR changed under us after decode; treat as illegal.
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end

            S_MULDIV: begin
                w_alu_op = w_aluop;
                if (bus.MulDivDone) state_d = S_WB;
            end

            S_MEM: begin
                w_addr_src  = 1'b1;
                w_mem_read  = (w_kind == K_LW);
                w_mem_write = (w_kind == K_SW);
                // A ready on the cycle the count would hit the limit completes
                // normally, so MemReady is tested before the timeout.
                if (bus.MemReady) begin
                    if (w_kind == K_LW) begin
                        state_d = S_WB;
                    end else begin
                        w_pc_write = 1'b1;
                        w_pc_src   = 2'd0;
                        retired_d  = retired_q + c_ONE;
                        state_d    = S_FETCH;
                    end
                end else if (w_wait_inc == c_TIMEOUT) begin
                    state_d  = S_HALT;
                    buserr_d = 1'b1;
                end else begin
                    wait_d = w_wait_inc;
                end
            end

            S_WB: begin
                w_reg_write = 1'b1;
                w_pc_write  = 1'b1;
                retired_d   = retired_q + c_ONE;
                state_d     = S_FETCH;
                case (w_kind)
                    K_LW:         w_wb_src = 3'd0;
                    K_JAL:        w_wb_src = 3'd2;
                    K_JALR:       w_wb_src = 3'd2;
                    K_LUI:        w_wb_src = 3'd3;
                    K_AUIPC:      w_wb_src = 3'd4;
                    default:      w_wb_src = 3'd1;
                endcase
                case (w_kind)
                    K_JAL:   w_pc_src = 2'd1;
                    K_JALR:  w_pc_src = 2'd2;
                    default: w_pc_src = 2'd0;
                endcase
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Whatever state the register holds while reset is applied, no
        // side-effecting strobe may leave the controller.
        if (rst) begin
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
            w_ir_write  = 1'b0;
            w_pc_write  = 1'b0;
            w_reg_write = 1'b0;
            w_md_start  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_q     <= '0;
            illegal_q  <= 1'b0;
            buserr_q   <= 1'b0;
            retired_q  <= '0;
            post_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            illegal_q  <= illegal_d;
            buserr_q   <= buserr_d;
            retired_q  <= retired_d;
            post_rst_q <= 1'b0;
        end
    end

    assign bus.MemRead      = w_mem_read;
    assign bus.MemWrite     = w_mem_write;
    assign bus.AddrSrc      = w_addr_src;
    assign bus.IRWrite      = w_ir_write;
    assign bus.PCWrite      = w_pc_write;
    assign bus.PCSrc        = w_pc_src;
    assign bus.ALUOp        = w_alu_op;
    assign bus.ALUSrcB      = w_alu_src_b;
    assign bus.RegWrite     = w_reg_write;
    assign bus.WritebackSrc = w_wb_src;
    assign bus.MulDivStart  = w_md_start;
    assign bus.Illegal      = illegal_q;
    assign bus.BusError     = buserr_q;
    assign bus.Retired      = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_main_controller_multicycle.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_main_controller_multicycle                                |
// | Purpose   : Self-checking bench for main_controller_multicycle. A table  |
// |             of instruction records drives one instruction at a time;     |
// |             expected results are queued and compared when the DUT        |
// |             retires. Hand sequences cover reset, timeout, illegal and    |
// |             reset-during-MULDIV; a second instance (no mul/div, 2-bit    |
// |             counter) covers illegal mul and counter wrap.                |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_main_controller_multicycle;

    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, rst2, sel;
    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [1:0] comp;
    logic       mem_ready, md_done;

    main_controller_multicycle_if #(.CNT_W(32)) bus1 ();
    main_controller_multicycle_if #(.CNT_W(2))  bus2 ();

    assign bus1.Opcode = opcode;   assign bus2.Opcode = opcode;
    assign bus1.Funct3 = f3;       assign bus2.Funct3 = f3;
    assign bus1.Funct7 = f7;       assign bus2.Funct7 = f7;
    assign bus1.Comp   = comp;     assign bus2.Comp   = comp;
    assign bus1.MemReady   = mem_ready;  assign bus2.MemReady   = mem_ready;
    assign bus1.MulDivDone = md_done;    assign bus2.MulDivDone = md_done;

    main_controller_multicycle #(.ENABLE_MULDIV(1), .MEM_TIMEOUT(TO), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1));
    main_controller_multicycle #(.ENABLE_MULDIV(0), .MEM_TIMEOUT(TO), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .bus(bus2));

    // Observation mux so the same checking code serves either instance.
    logic        w_memread, w_memwrite, w_irwrite, w_pcwrite, w_regwrite, w_start, w_ill, w_berr;
    logic [1:0]  w_pcsrc, w_srcb;
    logic [3:0]  w_alu;
    logic [2:0]  w_wb;
    logic [31:0] w_ret;
    always_comb begin
        if (sel) begin
            w_memread = bus2.MemRead;  w_memwrite = bus2.MemWrite; w_irwrite = bus2.IRWrite;
            w_pcwrite = bus2.PCWrite;  w_regwrite = bus2.RegWrite; w_start = bus2.MulDivStart;
            w_ill = bus2.Illegal;      w_berr = bus2.BusError;     w_pcsrc = bus2.PCSrc;
            w_srcb = bus2.ALUSrcB;     w_alu = bus2.ALUOp;         w_wb = bus2.WritebackSrc;
            w_ret = {30'd0, bus2.Retired};
        end else begin
            w_memread = bus1.MemRead;  w_memwrite = bus1.MemWrite; w_irwrite = bus1.IRWrite;
            w_pcwrite = bus1.PCWrite;  w_regwrite = bus1.RegWrite; w_start = bus1.MulDivStart;
            w_ill = bus1.Illegal;      w_berr = bus1.BusError;     w_pcsrc = bus1.PCSrc;
            w_srcb = bus1.ALUSrcB;     w_alu = bus1.ALUOp;         w_wb = bus1.WritebackSrc;
            w_ret = bus1.Retired;
        end
    end

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [1:0] comp;
        int         mdd;       // MULDIV cycle carrying MulDivDone; 0 = hold it high throughout
        int         mr;        // MEM cycle carrying MemReady; 0 = always ready
        bit         chk_exec;  // compare ALUOp/ALUSrcB in the EXEC cycle
        int         lat;
        logic [3:0] alu;
        logic [1:0] srcb;
        logic [2:0] wb;
        logic [1:0] pcsrc;
        int         regw;
        int         starts;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks, n_pass;
    int   exp_ret;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic vec_t mk(input string nm, input logic [6:0] op, input logic [2:0] fn3,
                                input logic [6:0] fn7, input logic [1:0] cp, input int mdd,
                                input int mr, input bit ce, input int lat, input logic [3:0] alu,
                                input logic [1:0] srcb, input logic [2:0] wb,
                                input logic [1:0] pcsrc, input int regw, input int starts);
        vec_t v;
        v.name = nm; v.op = op; v.f3 = fn3; v.f7 = fn7; v.comp = cp; v.mdd = mdd; v.mr = mr;
        v.chk_exec = ce; v.lat = lat; v.alu = alu; v.srcb = srcb; v.wb = wb; v.pcsrc = pcsrc;
        v.regw = regw; v.starts = starts;
        return v;
    endfunction

    function automatic logic [31:0] ret_model();
        return sel ? (exp_ret & 3) : exp_ret;
    endfunction

    // Runs one instruction from its FETCH cycle; must be entered just before that cycle's negedge.
    task automatic run_vec(input vec_t v);
        vec_t e;
        int   starts, rw;
        bit   done;
        opcode = v.op; f3 = v.f3; f7 = v.f7; comp = v.comp;
        sb.push_back(v);
        starts = 0; rw = 0; done = 0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            mem_ready = (v.mr == 0 || cyc < 4) ? 1'b1 : (cyc == 3 + v.mr);
            md_done   = (v.mdd == 0) ? 1'b1 : (cyc == 3 + v.mdd);
            #1;
            if (cyc == 1) check({v.name, " irwrite"}, 32'(w_irwrite), 32'd1);
            if (cyc == 3 && v.chk_exec) begin
                check({v.name, " aluop"}, 32'(w_alu), 32'(v.alu));
                check({v.name, " alusrcb"}, 32'(w_srcb), 32'(v.srcb));
            end
            if (w_start) starts++;
            if (w_regwrite) rw++;
            if (w_pcwrite) begin
                done = 1;
                e = sb.pop_front();
                check({e.name, " latency"}, 32'(cyc), 32'(e.lat));
                check({e.name, " pcsrc"}, 32'(w_pcsrc), 32'(e.pcsrc));
                check({e.name, " regwrite"}, 32'(rw), 32'(e.regw));
                check({e.name, " muldivstart"}, 32'(starts), 32'(e.starts));
                if (e.regw != 0) check({e.name, " wbsrc"}, 32'(w_wb), 32'(e.wb));
                @(posedge clk); #1;
                exp_ret++;
                check({e.name, " retired"}, w_ret, ret_model());
            end
        end
        if (!done) begin
            void'(sb.pop_front());
            check({v.name, " retire_timeout"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rw, pw, st;
        n_checks = 0; n_pass = 0; exp_ret = 0; sel = 1'b0;
        rst1 = 1'b1; rst2 = 1'b1;
        opcode = 7'h13; f3 = 3'd0; f7 = 7'h00; comp = 2'd0; mem_ready = 1'b1; md_done = 1'b1;

        //             name      op     f3 f7     cp mdd mr ce lat alu srcb wb pc rw st
        vecs.push_back(mk("addi",  7'h13, 0, 7'h00, 0, 0, 0, 1, 4,  0,  1,  1, 0, 1, 0));
        vecs.push_back(mk("andi",  7'h13, 7, 7'h00, 0, 0, 0, 1, 4,  4,  1,  1, 0, 1, 0));
        vecs.push_back(mk("ori",   7'h13, 6, 7'h00, 0, 0, 0, 1, 4,  3,  1,  1, 0, 1, 0));
        vecs.push_back(mk("xori",  7'h13, 4, 7'h00, 0, 0, 0, 1, 4,  2,  1,  1, 0, 1, 0));
        vecs.push_back(mk("slti",  7'h13, 2, 7'h00, 0, 0, 0, 1, 4,  7,  1,  1, 0, 1, 0));
        vecs.push_back(mk("srli",  7'h13, 5, 7'h00, 0, 0, 0, 1, 4,  6,  1,  1, 0, 1, 0));
        vecs.push_back(mk("add",   7'h33, 0, 7'h00, 0, 0, 0, 1, 4,  0,  0,  1, 0, 1, 0));
        vecs.push_back(mk("sub",   7'h33, 0, 7'h20, 0, 0, 0, 1, 4,  1,  0,  1, 0, 1, 0));
        vecs.push_back(mk("sll",   7'h33, 1, 7'h00, 0, 0, 0, 1, 4,  5,  0,  1, 0, 1, 0));
        vecs.push_back(mk("slt",   7'h33, 2, 7'h00, 0, 0, 0, 1, 4,  7,  0,  1, 0, 1, 0));
        vecs.push_back(mk("xor",   7'h33, 4, 7'h00, 0, 0, 0, 1, 4,  2,  0,  1, 0, 1, 0));
        vecs.push_back(mk("srl",   7'h33, 5, 7'h00, 0, 0, 0, 1, 4,  6,  0,  1, 0, 1, 0));
        vecs.push_back(mk("or",    7'h33, 6, 7'h00, 0, 0, 0, 1, 4,  3,  0,  1, 0, 1, 0));
        vecs.push_back(mk("and",   7'h33, 7, 7'h00, 0, 0, 0, 1, 4,  4,  0,  1, 0, 1, 0));
        vecs.push_back(mk("lw",    7'h03, 2, 7'h00, 0, 0, 0, 1, 5,  0,  1,  0, 0, 1, 0));
        vecs.push_back(mk("sw",    7'h23, 2, 7'h00, 0, 0, 0, 1, 4,  0,  1,  0, 0, 0, 0));
        vecs.push_back(mk("beq_t", 7'h63, 0, 7'h00, 0, 0, 0, 0, 3,  0,  0,  0, 1, 0, 0));
        vecs.push_back(mk("beq_n", 7'h63, 0, 7'h00, 2, 0, 0, 0, 3,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk("bne_n", 7'h63, 1, 7'h00, 0, 0, 0, 0, 3,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk("bne_t", 7'h63, 1, 7'h00, 1, 0, 0, 0, 3,  0,  0,  0, 1, 0, 0));
        vecs.push_back(mk("blt_t", 7'h63, 4, 7'h00, 1, 0, 0, 0, 3,  0,  0,  0, 1, 0, 0));
        vecs.push_back(mk("blt_n", 7'h63, 4, 7'h00, 0, 0, 0, 0, 3,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk("bge_e", 7'h63, 5, 7'h00, 0, 0, 0, 0, 3,  0,  0,  0, 1, 0, 0));
        vecs.push_back(mk("bge_g", 7'h63, 5, 7'h00, 2, 0, 0, 0, 3,  0,  0,  0, 1, 0, 0));
        vecs.push_back(mk("bge_n", 7'h63, 5, 7'h00, 1, 0, 0, 0, 3,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk("jal",   7'h6F, 0, 7'h00, 0, 0, 0, 1, 4, 15,  3,  2, 1, 1, 0));
        vecs.push_back(mk("jalr",  7'h67, 0, 7'h00, 0, 0, 0, 1, 4, 15,  3,  2, 2, 1, 0));
        vecs.push_back(mk("lui",   7'h37, 0, 7'h00, 0, 0, 0, 1, 4, 15,  3,  3, 0, 1, 0));
        vecs.push_back(mk("auipc", 7'h17, 0, 7'h00, 0, 0, 0, 1, 4, 15,  3,  4, 0, 1, 0));
        vecs.push_back(mk("mul",   7'h33, 0, 7'h01, 0, 6, 0, 1, 10, 8,  0,  1, 0, 1, 1));
        vecs.push_back(mk("div",   7'h33, 4, 7'h01, 0, 1, 0, 1, 5,  9,  0,  1, 0, 1, 1));
        vecs.push_back(mk("lw_edge", 7'h03, 2, 7'h00, 0, 0, TO, 1, 4 + TO, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk("sw_wait", 7'h23, 2, 7'h00, 0, 0, 3,  1, 6,  0,  1,  0, 0, 0, 0));

        // Reset: strobes forced low while rst is held, even with MemReady high.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst irwrite", 32'(w_irwrite), 32'd0);
        check("rst pcwrite", 32'(w_pcwrite), 32'd0);
        check("rst regwrite", 32'(w_regwrite), 32'd0);
        check("rst memwrite", 32'(w_memwrite), 32'd0);
        check("rst muldivstart", 32'(w_start), 32'd0);
        @(negedge clk); rst1 = 1'b0; #1;
        check("post_rst irwrite", 32'(w_irwrite), 32'd0);
        check("post_rst memread", 32'(w_memread), 32'd1);
        check("post_rst retired", w_ret, 32'd0);
        check("post_rst illegal", 32'(w_ill), 32'd0);
        check("post_rst buserror", 32'(w_berr), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);
        check("flags illegal", 32'(w_ill), 32'd0);
        check("flags buserror", 32'(w_berr), 32'd0);

        // Reset in the middle of a mul/div wait.
        opcode = 7'h33; f3 = 3'd0; f7 = 7'h01; md_done = 1'b0; mem_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("muldiv hold aluop", 32'(w_alu), 32'd8);
        check("muldiv no start", 32'(w_start), 32'd0);
        check("muldiv no memread", 32'(w_memread), 32'd0);
        check("muldiv no pcwrite", 32'(w_pcwrite), 32'd0);
        rst1 = 1'b1;
        @(negedge clk); rst1 = 1'b0; #1;
        exp_ret = 0;
        check("rst_muldiv retired", w_ret, 32'd0);
        check("rst_muldiv memread", 32'(w_memread), 32'd1);
        check("rst_muldiv irwrite", 32'(w_irwrite), 32'd0);
        md_done = 1'b1;

        // lw whose memory never answers.
        opcode = 7'h03; f3 = 3'd2; f7 = 7'h00;
        rw = 0; pw = 0;
        for (int cyc = 1; cyc <= 3 + TO; cyc++) begin
            @(negedge clk); mem_ready = (cyc < 4); #1;
            if (w_regwrite) rw++;
            if (w_pcwrite) pw++;
            if (cyc == 3 + TO) begin
                check("timeout last memread", 32'(w_memread), 32'd1);
                check("timeout last buserror", 32'(w_berr), 32'd0);
            end
        end
        @(negedge clk); #1;
        check("timeout buserror", 32'(w_berr), 32'd1);
        check("timeout memread", 32'(w_memread), 32'd0);
        check("timeout pcsrc", 32'(w_pcsrc), 32'd3);
        check("timeout regwrite", 32'(rw), 32'd0);
        check("timeout pcwrite", 32'(pw), 32'd0);
        check("timeout retired", w_ret, 32'(exp_ret));
        @(negedge clk); mem_ready = 1'b1; #1;
        check("halt hold irwrite", 32'(w_irwrite), 32'd0);
        check("halt hold memread", 32'(w_memread), 32'd0);
        rst1 = 1'b1;
        @(negedge clk); rst1 = 1'b0; #1;
        check("rst buserror clear", 32'(w_berr), 32'd0);
        check("rst memread", 32'(w_memread), 32'd1);

        // Undecodable opcode.
        opcode = 7'h7F; f3 = 3'd0; f7 = 7'h00;
        repeat (3) @(negedge clk);
        #1;
        check("illegal flag", 32'(w_ill), 32'd1);
        check("illegal pcsrc", 32'(w_pcsrc), 32'd3);
        check("illegal memread", 32'(w_memread), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check("illegal sticky", 32'(w_ill), 32'd1);
        check("illegal held pcsrc", 32'(w_pcsrc), 32'd3);
        rst1 = 1'b1;
        @(negedge clk); rst1 = 1'b0; #1;
        check("rst illegal clear", 32'(w_ill), 32'd0);

        // Second instance: 2-bit counter wrap, then mul decoded as illegal.
        rst1 = 1'b1; sel = 1'b1; exp_ret = 0;
        @(negedge clk); rst2 = 1'b0; #1;
        check("dut2 post_rst irwrite", 32'(w_irwrite), 32'd0);
        for (int k = 0; k < 5; k++) run_vec(vecs[0]);
        check("dut2 wrapped retired", w_ret, 32'd1);
        opcode = 7'h33; f3 = 3'd0; f7 = 7'h01; md_done = 1'b1; mem_ready = 1'b1;
        st = 0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk); #1;
            if (w_start) st++;
        end
        check("nomuldiv illegal", 32'(w_ill), 32'd1);
        check("nomuldiv pcsrc", 32'(w_pcsrc), 32'd3);
        check("nomuldiv memread", 32'(w_memread), 32'd0);
        check("nomuldiv start", 32'(st), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
